// File: rtl/recirc_return_buffer.sv
// rtl/recirc_return_buffer.sv - return-path buffer: captures Retorno words while inactive, re-injects them in order.
module recirc_return_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              active,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in_Retorno,
  input  logic              valid_in_Retorno,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow
);

  typedef enum logic [1:0] {PASS, STORE, DRAIN} state_t;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  state_t              state, state_n;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   rd_ptr, wr_ptr;
  logic                push_req, push, pop, drop;
  logic [DATA_W-1:0]   push_data;
  logic [DATA_W-1:0]   out_data;
  logic                out_valid;
  logic [ADDR_W:0]     count_n;

  always_comb begin
    state_n   = state;
    push_req  = 1'b0;
    push_data = data_in_Retorno;
    pop       = 1'b0;
    out_data  = data_out;
    out_valid = 1'b0;
    case (state)
      PASS: begin
        out_data  = data_in;
        out_valid = valid_in;
        if (!active) state_n = STORE;
      end
      STORE: begin
        push_req = valid_in_Retorno;
      end
      DRAIN: begin
        push_req  = valid_in;
        push_data = data_in;
        if (!active) begin
          state_n = STORE;
        end else begin
          pop       = 1'b1;
          out_data  = mem[rd_ptr];
          out_valid = 1'b1;
        end
      end
      default: state_n = PASS;
    endcase

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    push = push_req && (!full || pop);
    drop = push_req && full && !pop;

    case ({push, pop})
      2'b10:   count_n = count + (ADDR_W+1)'(1);
      2'b01:   count_n = count - (ADDR_W+1)'(1);
      default: count_n = count;
    endcase

    if (state == STORE && active) state_n = (count_n != '0) ? DRAIN : PASS;
    if (state == DRAIN && active && count_n == '0) state_n = PASS;
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state     <= PASS;
      data_out  <= '0;
      valid_out <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      overflow  <= 1'b0;
    end else begin
      state     <= state_n;
      data_out  <= out_data;
      valid_out <= out_valid;
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      count     <= count_n;
      full      <= (count_n == FULL_CNT);
      empty     <= (count_n == '0);
      overflow  <= overflow | drop;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: tb/tb_recirc_return_buffer.sv
// tb/tb_recirc_return_buffer.sv - randomized and directed check of recirc_return_buffer against a queue model.
module tb_recirc_return_buffer;

  localparam int DW = 32;
  localparam int M_PASS = 0, M_STORE = 1, M_DRAIN = 2;

  logic          clk = 1'b0;
  logic          reset_L, active, valid_in, valid_in_Retorno;
  logic [DW-1:0] data_in, data_in_Retorno;
  logic [DW-1:0] data_out;
  logic          valid_out, full, empty, overflow;
  logic [3:0]    count;

  int total = 0;
  int bad   = 0;

  int            mode;
  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_data;
  logic          exp_valid, exp_ovf;

  always #5 clk = ~clk;

  recirc_return_buffer dut (
    .clk(clk), .reset_L(reset_L), .active(active),
    .data_in(data_in), .valid_in(valid_in),
    .data_in_Retorno(data_in_Retorno), .valid_in_Retorno(valid_in_Retorno),
    .data_out(data_out), .valid_out(valid_out), .count(count),
    .full(full), .empty(empty), .overflow(overflow)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue plus the three operating modes.
  task automatic model_update();
    if (!reset_L) begin
      q.delete();
      mode = M_PASS; exp_data = '0; exp_valid = 1'b0; exp_ovf = 1'b0;
    end else begin
      case (mode)
        M_PASS: begin
          exp_data = data_in; exp_valid = valid_in;
          if (!active) mode = M_STORE;
        end
        M_STORE: begin
          exp_valid = 1'b0;
          if (valid_in_Retorno) begin
            if (q.size() < 8) q.push_back(data_in_Retorno); else exp_ovf = 1'b1;
          end
          if (active) mode = (q.size() != 0) ? M_DRAIN : M_PASS;
        end
        default: begin
          if (!active) begin
            exp_valid = 1'b0;
            if (valid_in) begin
              if (q.size() < 8) q.push_back(data_in); else exp_ovf = 1'b1;
            end
            mode = M_STORE;
          end else begin
            exp_data = q.pop_front(); exp_valid = 1'b1;
            if (valid_in) q.push_back(data_in);
            if (q.size() == 0) mode = M_PASS;
          end
        end
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    chk("m_valid", DW'(valid_out), DW'(exp_valid));
    chk("m_data", data_out, exp_data);
    chk("m_count", DW'(count), DW'(q.size()));
    chk("m_full", DW'(full), DW'(q.size() == 8));
    chk("m_empty", DW'(empty), DW'(q.size() == 0));
    chk("m_ovf", DW'(overflow), DW'(exp_ovf));
  endtask

  logic [DW-1:0] lit3 [3] = '{32'h1, 32'hABCE, 32'h1579B};
  logic [DW-1:0] fresh [6] = '{32'hEFAB, 32'h1DF56, 32'h2468, 32'h3579, 32'h4680, 32'h5791};

  initial begin
    reset_L = 1'b0; active = 1'b1; valid_in = 1'b1; data_in = 32'hABCD;
    valid_in_Retorno = 1'b0; data_in_Retorno = '0;
    mode = M_PASS; exp_data = '0; exp_valid = 1'b0; exp_ovf = 1'b0;
    @(negedge clk);
    step(); step();
    chk("rst_valid", DW'(valid_out), 32'h0);
    chk("rst_data", data_out, 32'h0);
    chk("rst_count", DW'(count), 32'h0);
    chk("rst_empty", DW'(empty), 32'h1);

    // pass-through
    reset_L = 1'b1; data_in = 32'h0000ABCD; step();
    chk("pass_data", data_out, 32'h0000ABCD);
    chk("pass_valid", DW'(valid_out), 32'h1);
    valid_in = 1'b0; step();
    chk("pass_idle", DW'(valid_out), 32'h0);

    // store three, drain three
    active = 1'b0; step();
    valid_in_Retorno = 1'b1;
    for (int i = 0; i < 3; i++) begin data_in_Retorno = lit3[i]; step(); end
    valid_in_Retorno = 1'b0;
    chk("st3_count", DW'(count), 32'd3);
    chk("st3_valid", DW'(valid_out), 32'h0);
    active = 1'b1; step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("dr3_valid", DW'(valid_out), 32'h1);
      chk("dr3_data", data_out, lit3[i]);
    end
    chk("dr3_empty", DW'(empty), 32'h1);
    step();
    chk("dr3_pass", DW'(valid_out), 32'h0);

    // overflow
    active = 1'b0; step();
    valid_in_Retorno = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data_in_Retorno = 32'h100 + i; step();
      if (i == 7) begin
        chk("of_full", DW'(full), 32'h1);
        chk("of_noovf", DW'(overflow), 32'h0);
      end
      if (i == 8) chk("of_ovf", DW'(overflow), 32'h1);
    end
    valid_in_Retorno = 1'b0;
    chk("of_count", DW'(count), 32'd8);
    active = 1'b1; step();
    for (int i = 0; i < 8; i++) begin
      step();
      chk("of_data", data_out, 32'h100 + i);
    end
    step();
    chk("of_sticky", DW'(overflow), 32'h1);
    chk("of_empty", DW'(empty), 32'h1);

    // ordering of fresh words behind stored ones
    active = 1'b0; step();
    valid_in_Retorno = 1'b1;
    data_in_Retorno = 32'h55; step();
    data_in_Retorno = 32'h66; step();
    valid_in_Retorno = 1'b0; active = 1'b1; step();
    for (int k = 0; k < 6; k++) begin
      valid_in = 1'b1; data_in = fresh[k]; step();
      chk("ord_count", DW'(count), 32'd2);
      chk("ord_data", data_out, (k == 0) ? 32'h55 : (k == 1) ? 32'h66 : fresh[k-2]);
    end
    valid_in = 1'b0; step(); step();
    chk("ord_tail", data_out, fresh[5]);

    // suspend a drain, then reset
    reset_L = 1'b0; step(); reset_L = 1'b1;
    active = 1'b0; step();
    valid_in_Retorno = 1'b1;
    for (int i = 0; i < 5; i++) begin data_in_Retorno = 32'h200 + i; step(); end
    valid_in_Retorno = 1'b0; active = 1'b1; step();
    valid_in = 1'b1; data_in = 32'h300; step();
    valid_in = 1'b0;
    chk("mid_count5", DW'(count), 32'd5);
    active = 1'b0; valid_in_Retorno = 1'b1; data_in_Retorno = 32'h400;
    step(); step(); step();
    valid_in_Retorno = 1'b0;
    chk("mid_count7", DW'(count), 32'd7);
    chk("mid_nooutput", DW'(valid_out), 32'h0);
    reset_L = 1'b0; step();
    chk("mid_rst_count", DW'(count), 32'h0);
    chk("mid_rst_valid", DW'(valid_out), 32'h0);
    reset_L = 1'b1; active = 1'b1; valid_in = 1'b1; data_in = 32'h77; step();
    chk("mid_rst_pass", data_out, 32'h77);

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      reset_L = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 9) == 0) active = ~active;
      valid_in = $urandom_range(0, 2) != 0;
      data_in = $urandom;
      valid_in_Retorno = $urandom_range(0, 3) != 0;
      data_in_Retorno = $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
